// File: rtl/async_wr_ctrl_lvl.sv
// Dual-clock FIFO write controller: rd_ptr synchroniser, registered full/afull/fill level, accept strobe.
// Latency: wr_accept is same-cycle; full/count see reads SYNC_STAGES+1 edges late. Backpressure: writes are refused while wr_full.
// Optional sticky wr_overflow port: ASYNC_WR_CTRL_OVERFLOW_EN.
module async_wr_ctrl_lvl #(
  parameter  int DEPTH       = 16,
  parameter  int SYNC_STAGES = 2,
  localparam int AWIDTH      = $clog2(DEPTH)
) (
  input  logic              wr_clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AWIDTH:0]   rd_ptr,
  input  logic [AWIDTH:0]   afull_thresh,
  output logic [AWIDTH-1:0] wr_addr,
  output logic [AWIDTH:0]   wr_ptr,
  output logic              wr_accept,
  output logic              wr_full,
  output logic              wr_afull,
  output logic [AWIDTH:0]   wr_count
`ifdef ASYNC_WR_CTRL_OVERFLOW_EN
  ,
  output logic              wr_overflow
`endif
);

  logic [AWIDTH:0] rd_sync_q [SYNC_STAGES];
  logic [AWIDTH:0] rd_sync;
  logic [AWIDTH:0] rd_sync_bin;
  logic [AWIDTH:0] wr_ptr_bin;
  logic [AWIDTH:0] bin_next;
  logic [AWIDTH:0] level_next;

  // Plain flop chain: no logic between stages so each Gray bit resolves independently.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) rd_sync_q[i] <= '0;
    end else begin
      rd_sync_q[0] <= rd_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) rd_sync_q[i] <= rd_sync_q[i-1];
    end
  end

  assign rd_sync = rd_sync_q[SYNC_STAGES-1];

  always_comb begin
    rd_sync_bin = '0;
    for (int i = 0; i <= AWIDTH; i++) rd_sync_bin[i] = ^(rd_sync >> i);
  end

  assign wr_accept  = wr_en & ~wr_full;
  assign bin_next   = wr_ptr_bin + (AWIDTH+1)'(wr_accept);
  assign level_next = bin_next - rd_sync_bin;
  assign wr_addr    = wr_ptr_bin[AWIDTH-1:0];

  // Flags look at bin_next so full rises on the edge that takes the last free slot.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_bin <= '0;
      wr_ptr     <= '0;
      wr_full    <= 1'b0;
      wr_afull   <= 1'b0;
      wr_count   <= '0;
    end else begin
      wr_ptr_bin <= bin_next;
      wr_ptr     <= bin_next ^ (bin_next >> 1);
      wr_full    <= (bin_next == {~rd_sync_bin[AWIDTH], rd_sync_bin[AWIDTH-1:0]});
      wr_afull   <= (level_next >= afull_thresh);
      wr_count   <= level_next;
    end
  end

`ifdef ASYNC_WR_CTRL_OVERFLOW_EN
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) wr_overflow <= 1'b0;
    else        wr_overflow <= wr_overflow | (wr_en & wr_full);
  end
`endif

endmodule

// File: tb/tb_async_wr_ctrl_lvl.sv
// Directed bench for async_wr_ctrl_lvl at DEPTH=8, SYNC_STAGES=2.
module tb_async_wr_ctrl_lvl;

  logic       wr_clk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       wr_en  = 1'b0;
  logic [3:0] rd_ptr = '0;
  logic [3:0] afull_thresh = '0;
  logic [2:0] wr_addr;
  logic [3:0] wr_ptr;
  logic       wr_accept;
  logic       wr_full;
  logic       wr_afull;
  logic [3:0] wr_count;
`ifdef ASYNC_WR_CTRL_OVERFLOW_EN
  logic       wr_overflow;
`endif

  int checks = 0;
  int errors = 0;

  async_wr_ctrl_lvl #(.DEPTH(8), .SYNC_STAGES(2)) dut (
    .wr_clk       (wr_clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .rd_ptr       (rd_ptr),
    .afull_thresh (afull_thresh),
    .wr_addr      (wr_addr),
    .wr_ptr       (wr_ptr),
    .wr_accept    (wr_accept),
    .wr_full      (wr_full),
    .wr_afull     (wr_afull),
    .wr_count     (wr_count)
`ifdef ASYNC_WR_CTRL_OVERFLOW_EN
    ,
    .wr_overflow  (wr_overflow)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct {
    logic       en;
    logic [3:0] rd;
    logic       acc;
    logic [2:0] addr;
    logic       full;
    logic       afull;
    logic [3:0] cnt;
    logic [3:0] ptr;
  } vec_t;

  vec_t vt[$];

  function automatic logic [3:0] gray(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  function automatic vec_t mk(input logic en, input logic [3:0] rd, input logic acc,
                              input logic [2:0] addr, input logic full, input logic afull,
                              input logic [3:0] cnt, input logic [3:0] ptr);
    vec_t v;
    v.en = en; v.rd = rd; v.acc = acc; v.addr = addr;
    v.full = full; v.afull = afull; v.cnt = cnt; v.ptr = ptr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n  = 1'b0;
    wr_en  = 1'b0;
    rd_ptr = '0;
    @(posedge wr_clk);
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [3:0] prev_ptr;

    // Reset asserted mid-cycle must clear outputs without a clock edge.
    afull_thresh = 4'd1;
    repeat (2) @(posedge wr_clk);
    #3 rst_n = 1'b1;
    wr_en = 1'b1;
    tick();
    tick();
    wr_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_addr",  wr_addr,   0);
    check("rst_ptr",   wr_ptr,    0);
    check("rst_full",  wr_full,   0);
    check("rst_afull", wr_afull,  0);
    check("rst_count", wr_count,  0);
    check("rst_acc",   wr_accept, 0);
`ifdef ASYNC_WR_CTRL_OVERFLOW_EN
    check("rst_ovf",   wr_overflow, 0);
`endif
    @(posedge wr_clk);
    #3 rst_n = 1'b1;

    // Fill, overflow attempts, drain visibility, then one more write.
    afull_thresh = 4'd6;
    for (int k = 1; k <= 8; k++)
      vt.push_back(mk(1'b1, 4'd0, 1'b1, 3'(k-1), k == 8, k >= 6, 4'(k), gray(k)));
    for (int k = 0; k < 3; k++)
      vt.push_back(mk(1'b1, 4'd0, 1'b0, 3'd0, 1'b1, 1'b1, 4'd8, 4'b1100));
    vt.push_back(mk(1'b0, 4'b0010, 1'b0, 3'd0, 1'b1, 1'b1, 4'd8, 4'b1100));
    vt.push_back(mk(1'b0, 4'b0010, 1'b0, 3'd0, 1'b1, 1'b1, 4'd8, 4'b1100));
    vt.push_back(mk(1'b0, 4'b0010, 1'b0, 3'd0, 1'b0, 1'b0, 4'd5, 4'b1100));
    vt.push_back(mk(1'b1, 4'b0010, 1'b1, 3'd0, 1'b0, 1'b1, 4'd6, 4'b1101));

    foreach (vt[i]) begin
      wr_en  = vt[i].en;
      rd_ptr = vt[i].rd;
      #1;
      check($sformatf("v%0d_acc", i),  wr_accept, vt[i].acc);
      check($sformatf("v%0d_addr", i), wr_addr,   vt[i].addr);
      tick();
      check($sformatf("v%0d_full", i),  wr_full,  vt[i].full);
      check($sformatf("v%0d_afull", i), wr_afull, vt[i].afull);
      check($sformatf("v%0d_cnt", i),   wr_count, vt[i].cnt);
      check($sformatf("v%0d_ptr", i),   wr_ptr,   vt[i].ptr);
    end
`ifdef ASYNC_WR_CTRL_OVERFLOW_EN
    check("ovf_sticky", wr_overflow, 1);
`endif

    // Wrap: reader trails 4 writes behind; pointer rolls 1000 -> 0000.
    reset_dut();
    prev_ptr = wr_ptr;
    for (int k = 0; k < 20; k++) begin
      wr_en  = 1'b1;
      rd_ptr = gray((k >= 4) ? k - 4 : 0);
      #1;
      check($sformatf("wrap%0d_addr", k), wr_addr, k % 8);
      check($sformatf("wrap%0d_acc", k),  wr_accept, 1);
      tick();
      check($sformatf("wrap%0d_ptr", k),  wr_ptr, gray((k + 1) % 16));
      check($sformatf("wrap%0d_step", k), $countones(wr_ptr ^ prev_ptr), 1);
      check($sformatf("wrap%0d_full", k), wr_full, 0);
      check($sformatf("wrap%0d_cnt", k),  wr_count, (k + 1 < 7) ? k + 1 : 7);
      prev_ptr = wr_ptr;
    end

    // Reset mid-fill must also clear the synchroniser.
    reset_dut();
    wr_en = 1'b1;
    repeat (5) tick();
    wr_en  = 1'b0;
    rd_ptr = gray(2);
    repeat (3) tick();
    check("mid_cnt_pre", wr_count, 3);
    #2 rst_n = 1'b0;
    rd_ptr = '0;
    #1;
    check("mid_cnt", wr_count, 0);
    check("mid_ptr", wr_ptr,   0);
    check("mid_addr", wr_addr, 0);
    @(posedge wr_clk);
    #3 rst_n = 1'b1;
    wr_en = 1'b1;
    #1;
    check("mid_first_addr", wr_addr, 0);
    tick();
    wr_en = 1'b0;
    check("mid_first_cnt", wr_count, 1);
    check("mid_first_ptr", wr_ptr,   4'b0001);

    // Threshold extremes.
    reset_dut();
    afull_thresh = 4'd0;
    tick();
    check("th0_afull", wr_afull, 1);
    afull_thresh = 4'd9;
    wr_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("th9_afull%0d", k), wr_afull, 0);
    end
    wr_en = 1'b0;
    check("th9_full", wr_full, 1);
    check("th9_cnt",  wr_count, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
